alarm_ctrl: RTL and testbench

Alarm controller consuming the hour/minute/second counts and the 1 Hz tick from the clock counter chain. Holds a user-settable alarm time, detects the wake time and drives a ringing FSM with stop, snooze and auto-silence. Outputs feed the LED/buzzer pins and the seven-segment display mux, which shows the alarm time while `set_en` is high.

---
 rtl/alarm_ctrl.sv | 160 ++++++++++++++++
 tb/tb_alarm_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: settable alarm time, wake detection and ringing FSM with stop/auto-silence.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
  parameter int unsigned RST_HOUR     = 7,
  parameter int unsigned RST_MIN      = 0,
  parameter int unsigned RING_MAX_SEC = 60,
  parameter int unsigned SNOOZE_MIN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [5:0] sec_count,
  input  logic [5:0] min_count,
  input  logic [4:0] hour_count,
  input  logic       arm,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic [5:0] alarm_min,
  output logic [4:0] alarm_hour,
  output logic       ringing,
  output logic       beep,
  output logic       snooze_active
);

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

  localparam logic [11:0] RingMax = 12'(RING_MAX_SEC);

  state_e      state_q, state_d;
  logic [5:0]  alarm_min_q, alarm_min_d;
  logic [4:0]  alarm_hour_q, alarm_hour_d;
  logic [11:0] ring_cnt_q, ring_cnt_d;
  logic        phase_q, phase_d;
  logic        match, match_q, match_rise;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SnoozeMax = 12'(SNOOZE_MIN * 60);
  logic [11:0] snz_cnt_q, snz_cnt_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_btn | (SNOOZE_MIN == 0);
`endif

  // Editing suppresses the match so the display can pass through the current time harmlessly.
  assign match = (hour_count == alarm_hour_q) && (min_count == alarm_min_q) &&
                 (sec_count == 6'd0) && !set_en;
  assign match_rise = match && !match_q;

  always_comb begin
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    if (set_en && inc_min) begin
      alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
    end
    if (set_en && inc_hour) begin
      alarm_hour_d = (alarm_hour_q == 5'd23) ? 5'd0 : alarm_hour_q + 5'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    phase_d    = phase_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (arm) state_d = StArmed;
      end
      StArmed: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (match_rise) begin
          state_d    = StRinging;
          ring_cnt_d = 12'd0;
          phase_d    = 1'b0;
        end
      end
      StRinging: begin
        if (tick) begin
          ring_cnt_d = sat_inc(ring_cnt_q);
          phase_d    = ~phase_q;
        end
        if (!arm) begin
          state_d = StIdle;
        end else if (stop_btn) begin
          state_d = StArmed;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_btn) begin
          state_d   = StSnooze;
          snz_cnt_d = 12'd0;
`endif
        end else if (tick && (sat_inc(ring_cnt_q) == RingMax)) begin
          state_d = StArmed;
        end
      end
`ifdef ALARM_SNOOZE_EN
      StSnooze: begin
        if (tick) snz_cnt_d = sat_inc(snz_cnt_q);
        if (!arm) begin
          state_d = StIdle;
        end else if (stop_btn) begin
          state_d = StArmed;
        end else if (tick && (sat_inc(snz_cnt_q) == SnoozeMax)) begin
          state_d    = StRinging;
          ring_cnt_d = 12'd0;
          phase_d    = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      alarm_min_q  <= 6'(RST_MIN);
      alarm_hour_q <= 5'(RST_HOUR);
      ring_cnt_q   <= 12'd0;
      phase_q      <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      ring_cnt_q   <= ring_cnt_d;
      phase_q      <= phase_d;
      match_q      <= match;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      snz_cnt_q <= 12'd0;
    end else begin
      snz_cnt_q <= snz_cnt_d;
    end
  end

  assign snooze_active = (state_q == StSnooze);
`else
  assign snooze_active = 1'b0;
`endif

  assign alarm_min  = alarm_min_q;
  assign alarm_hour = alarm_hour_q;
  assign ringing    = (state_q == StRinging);
  assign beep       = ringing & phase_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: edit vectors from a table, then hand-written ring,
// stop, disarm, snooze and reset sequences, all checked through an expectation queue.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, arm, set_en, inc_min, inc_hour, stop_btn, snooze_btn;
  logic [5:0] sec_count, min_count;
  logic [4:0] hour_count;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hour;
  logic       ringing, beep, snooze_active;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RST_HOUR    (7),
    .RST_MIN     (0),
    .RING_MAX_SEC(60),
    .SNOOZE_MIN  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .sec_count    (sec_count),
    .min_count    (min_count),
    .hour_count   (hour_count),
    .arm          (arm),
    .set_en       (set_en),
    .inc_min      (inc_min),
    .inc_hour     (inc_hour),
    .stop_btn     (stop_btn),
    .snooze_btn   (snooze_btn),
    .alarm_min    (alarm_min),
    .alarm_hour   (alarm_hour),
    .ringing      (ringing),
    .beep         (beep),
    .snooze_active(snooze_active)
  );

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic       ring;
    logic       beep;
    logic       snz;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } sb_t;

  typedef struct {
    bit    se;
    bit    im;
    bit    ih;
    out_t  e;
    string name;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  out_t nul = '0;

  function automatic out_t o(int h, int m, bit r, bit b, bit s);
    out_t v;
    v.hour = 5'(h);
    v.min  = 6'(m);
    v.ring = r;
    v.beep = b;
    v.snz  = s;
    return v;
  endfunction

  // One clock: queue the expectation, let the edge pass, compare away from it, drop pulses.
  task automatic cyc(input bit chk, input out_t e, input string name);
    sb_t  s;
    out_t act;
    if (chk) begin
      s.exp  = e;
      s.name = name;
      sb_q.push_back(s);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      s   = sb_q.pop_front();
      act = {alarm_hour, alarm_min, ringing, beep, snooze_active};
      n_cmp++;
      if (act !== s.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d:%0d ring=%b beep=%b snz=%b, want %0d:%0d ring=%b beep=%b snz=%b",
                 s.name, act.hour, act.min, act.ring, act.beep, act.snz,
                 s.exp.hour, s.exp.min, s.exp.ring, s.exp.beep, s.exp.snz);
      end
    end
    tick       = 1'b0;
    inc_min    = 1'b0;
    inc_hour   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour_count = 5'(h);
    min_count  = 6'(m);
    sec_count  = 6'(s);
  endtask

  task automatic adv_time();
    if (sec_count == 6'd59) begin
      sec_count = 6'd0;
      if (min_count == 6'd59) begin
        min_count  = 6'd0;
        hour_count = (hour_count == 5'd23) ? 5'd0 : hour_count + 5'd1;
      end else begin
        min_count = min_count + 6'd1;
      end
    end else begin
      sec_count = sec_count + 6'd1;
    end
  endtask

  // Tick cycle at the current time; the counters move on afterwards, as the counter chain does.
  task automatic sec_tick(input bit chk, input out_t e, input string name);
    tick = 1'b1;
    cyc(chk, e, name);
    adv_time();
  endtask

  task automatic retrigger(input string name);
    set_time(6, 59, 59);
    cyc(0, nul, "");
    set_time(7, 0, 0);
    cyc(1, o(7, 0, 1, 0, 0), name);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; arm = 1'b0; set_en = 1'b0;
    inc_min = 1'b0; inc_hour = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    set_time(12, 34, 56);
    cyc(1, o(7, 0, 0, 0, 0), "reset");

    vt[0] = '{0, 1, 0, o(7, 0, 0, 0, 0), "min_gated"};
    vt[1] = '{1, 1, 0, o(7, 1, 0, 0, 0), "min_inc"};
    vt[2] = '{1, 0, 1, o(8, 1, 0, 0, 0), "hour_inc"};
    vt[3] = '{1, 1, 1, o(9, 2, 0, 0, 0), "both_inc"};
    vt[4] = '{1, 0, 0, o(9, 2, 0, 0, 0), "hold"};
    vt[5] = '{0, 0, 1, o(9, 2, 0, 0, 0), "hour_gated"};
    for (int i = 0; i < 6; i++) begin
      set_en   = vt[i].se;
      inc_min  = vt[i].im;
      inc_hour = vt[i].ih;
      cyc(1, vt[i].e, vt[i].name);
    end

    set_en = 1'b1;
    for (int i = 0; i < 56; i++) begin
      inc_min = 1'b1;
      cyc(0, nul, "");
    end
    inc_min = 1'b1;
    cyc(1, o(9, 59, 0, 0, 0), "min_59");
    inc_min = 1'b1;
    cyc(1, o(9, 0, 0, 0, 0), "min_wrap");
    for (int i = 0; i < 13; i++) begin
      inc_hour = 1'b1;
      cyc(0, nul, "");
    end
    inc_hour = 1'b1;
    cyc(1, o(23, 0, 0, 0, 0), "hour_23");
    inc_hour = 1'b1;
    cyc(1, o(0, 0, 0, 0, 0), "hour_wrap");

    set_en = 1'b0;
    rst    = 1'b1;
    cyc(1, o(7, 0, 0, 0, 0), "rst_restore");

    // Alarm time on the counters while editing must not ring.
    arm    = 1'b1;
    set_en = 1'b1;
    set_time(7, 0, 0);
    cyc(1, o(7, 0, 0, 0, 0), "set_en_arming");
    cyc(1, o(7, 0, 0, 0, 0), "set_en_no_ring");
    set_time(7, 0, 1);
    set_en = 1'b0;
    cyc(1, o(7, 0, 0, 0, 0), "set_en_released");

    // Wake-up, beep phase and auto-silence.
    set_time(6, 59, 59);
    cyc(1, o(7, 0, 0, 0, 0), "armed_wait");
    sec_tick(1, o(7, 0, 0, 0, 0), "pre_match");
    cyc(1, o(7, 0, 1, 0, 0), "ring_onset");
    sec_tick(1, o(7, 0, 1, 1, 0), "beep_on");
    cyc(0, nul, "");
    sec_tick(1, o(7, 0, 1, 0, 0), "beep_off");
    for (int i = 0; i < 57; i++) sec_tick(0, nul, "");
    cyc(1, o(7, 0, 1, 1, 0), "ring_59");
    sec_tick(1, o(7, 0, 0, 0, 0), "auto_silence");

    // Stop beats snooze; the held 07:00:00 second must not re-trigger.
    retrigger("retrigger_stop");
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    cyc(1, o(7, 0, 0, 0, 0), "stop_wins");
    cyc(0, nul, "");
    cyc(0, nul, "");
    cyc(1, o(7, 0, 0, 0, 0), "no_retrigger");

    // Disarm with stop lands in IDLE, where a fresh match is not honoured.
    retrigger("retrigger_disarm");
    set_time(6, 59, 59);
    arm      = 1'b0;
    stop_btn = 1'b1;
    cyc(1, o(7, 0, 0, 0, 0), "disarm_stop");
    arm = 1'b1;
    set_time(7, 0, 0);
    cyc(1, o(7, 0, 0, 0, 0), "idle_no_ring");
    cyc(1, o(7, 0, 0, 0, 0), "idle_no_ring2");

    retrigger("retrigger_snooze");
    sec_tick(1, o(7, 0, 1, 1, 0), "beep_before_snooze");
    snooze_btn = 1'b1;
`ifdef ALARM_SNOOZE_EN
    cyc(1, o(7, 0, 0, 0, 1), "snooze_enter");
    for (int i = 0; i < 59; i++) sec_tick(0, nul, "");
    cyc(1, o(7, 0, 0, 0, 1), "snooze_59");
    sec_tick(1, o(7, 0, 1, 0, 0), "snooze_expire");
    snooze_btn = 1'b1;
    cyc(1, o(7, 0, 0, 0, 1), "snooze_again");
    set_en   = 1'b1;
    inc_hour = 1'b1;
    cyc(1, o(8, 0, 0, 0, 1), "edit_in_snooze");
    set_en = 1'b0;
    sec_tick(0, nul, "");
    sec_tick(0, nul, "");
    rst = 1'b1;
    cyc(1, o(7, 0, 0, 0, 0), "rst_mid_snooze");
`else
    cyc(1, o(7, 0, 1, 1, 0), "snooze_ignored");
    for (int i = 0; i < 30; i++) sec_tick(0, nul, "");
    cyc(1, o(7, 0, 1, 1, 0), "ring_holds");
    set_en   = 1'b1;
    inc_hour = 1'b1;
    cyc(1, o(8, 0, 1, 1, 0), "edit_in_ring");
    set_en = 1'b0;
    sec_tick(0, nul, "");
    rst = 1'b1;
    cyc(1, o(7, 0, 0, 0, 0), "rst_mid_ring");
`endif
    cyc(1, o(7, 0, 0, 0, 0), "post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
